// File: rtl/verifier_chi_dot_accum_pkg.sv
// Shared field parameters and modular helpers for the chi dot-product accumulator.
// Field is GF(p) with p = 65521, the largest 16-bit prime.
package verifier_chi_dot_accum_pkg;

    localparam int F_NBITS = 16;
    localparam logic [F_NBITS-1:0] FIELD_P = 16'd65521;

    // Operands must already be reduced (< p), so one conditional subtract suffices.
    function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, FIELD_P}) begin
            sum = sum - {1'b0, FIELD_P};
        end
        return sum[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/verifier_chi_dot_accum_field.sv
// Field arithmetic units with an en/ready handshake: ready drops the cycle en is seen
// and returns high once c holds the reduced result.

module field_multiplier
    import verifier_chi_dot_accum_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic               ready,
    output logic [F_NBITS-1:0] c
);
    localparam int CW = $clog2(F_NBITS);

    logic               busy_reg;
    logic [CW-1:0]      cnt_reg;
    logic [F_NBITS-1:0] a_reg;
    logic [F_NBITS-1:0] b_reg;
    logic [F_NBITS-1:0] acc_reg;
    logic [F_NBITS-1:0] dbl;
    logic [F_NBITS-1:0] acc_next;

    // MSB-first double-and-add keeps every intermediate reduced.
    always_comb begin
        dbl      = mod_add(acc_reg, acc_reg);
        acc_next = b_reg[F_NBITS-1] ? mod_add(dbl, a_reg) : dbl;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
        end else if (!busy_reg) begin
            if (en) begin
                busy_reg <= 1'b1;
                cnt_reg  <= CW'(F_NBITS - 1);
                a_reg    <= a;
                b_reg    <= b;
                acc_reg  <= '0;
            end
        end else begin
            acc_reg <= acc_next;
            b_reg   <= b_reg << 1;
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign ready = ~busy_reg & ~en;
    assign c     = acc_reg;

endmodule

module field_adder
    import verifier_chi_dot_accum_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic               ready,
    output logic [F_NBITS-1:0] c
);
    logic               busy_reg;
    logic [F_NBITS-1:0] sum_reg;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy_reg <= 1'b0;
            sum_reg  <= '0;
        end else if (!busy_reg) begin
            if (en) begin
                busy_reg <= 1'b1;
                sum_reg  <= mod_add(a, b);
            end
        end else begin
            busy_reg <= 1'b0;
        end
    end

    assign ready = ~busy_reg & ~en;
    assign c     = sum_reg;

endmodule

// File: rtl/verifier_chi_dot_accum.sv
// Accumulates sum_i chi[i]*vals[i] mod p over one chunk of nValues elements, one element
// at a time through a shared multiplier and adder; optionally requests a chi shift at the end.
module verifier_chi_dot_accum
    import verifier_chi_dot_accum_pkg::*;
#(
    parameter int nValBits = 2,
    parameter int nValues  = 1 << nValBits
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             en,
    input  logic                             clr_acc,
    input  logic                             shift_req,
    input  logic [nValues-1:0][F_NBITS-1:0]  chi_in,
    input  logic [nValues-1:0][F_NBITS-1:0]  vals_in,
    output logic                             chi_shen,
    output logic                             ready,
    output logic [F_NBITS-1:0]               result
);
    if (nValBits < 1) begin : g_bad_nvalbits
        $error("nValBits must be >= 1");
    end
    if (nValues != (1 << nValBits)) begin : g_bad_nvalues
        $error("nValues is derived from nValBits and must not be overridden");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_ST,
        ST_MUL,
        ST_ADD_ST,
        ST_ADD,
        ST_NEXT
    } state_t;

    state_t               state_reg;
    logic [nValBits-1:0]  idx_reg;
    logic [F_NBITS-1:0]   acc_reg;
    logic                 en_dly_reg;
    logic                 shift_lat_reg;
    logic                 skip_reg;

    logic                 start;
    logic                 last;
    logic                 zero_elem;
    logic [F_NBITS-1:0]   chi_sel;
    logic [F_NBITS-1:0]   val_sel;
    logic                 mul_en;
    logic                 mul_ready;
    logic [F_NBITS-1:0]   mul_out;
    logic                 add_en;
    logic                 add_ready;
    logic [F_NBITS-1:0]   add_out;

    assign start     = en & ~en_dly_reg;
    assign chi_sel   = chi_in[idx_reg];
    assign val_sel   = vals_in[idx_reg];
    assign zero_elem = (chi_sel == '0) || (val_sel == '0);
    assign last      = (idx_reg == nValBits'(nValues - 1));
    assign mul_en    = (state_reg == ST_MUL_ST) & ~zero_elem;
    assign add_en    = (state_reg == ST_ADD_ST);

    field_multiplier u_mul (
        .clk   (clk),
        .rstb  (rstb),
        .en    (mul_en),
        .a     (chi_sel),
        .b     (val_sel),
        .ready (mul_ready),
        .c     (mul_out)
    );

    field_adder u_add (
        .clk   (clk),
        .rstb  (rstb),
        .en    (add_en),
        .a     (acc_reg),
        .b     (mul_out),
        .ready (add_ready),
        .c     (add_out)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            acc_reg       <= '0;
            en_dly_reg    <= 1'b1;
            shift_lat_reg <= 1'b0;
            skip_reg      <= 1'b0;
        end else begin
            en_dly_reg <= en;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        idx_reg       <= '0;
                        shift_lat_reg <= shift_req;
                        if (clr_acc) begin
                            acc_reg <= '0;
                        end
                        state_reg <= ST_MUL_ST;
                    end
                end
                ST_MUL_ST: begin
                    // A zero factor contributes nothing, so bypass both field units.
                    if (zero_elem) begin
                        skip_reg  <= 1'b1;
                        state_reg <= ST_NEXT;
                    end else begin
                        skip_reg  <= 1'b0;
                        state_reg <= mul_ready ? ST_ADD_ST : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_ready) begin
                        state_reg <= ST_ADD_ST;
                    end
                end
                ST_ADD_ST: begin
                    state_reg <= add_ready ? ST_NEXT : ST_ADD;
                end
                ST_ADD: begin
                    if (add_ready) begin
                        state_reg <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!skip_reg) begin
                        acc_reg <= add_out;
                    end
                    if (last) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= ST_MUL_ST;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Producer shifts on the edge that also returns us to idle, so chi_in
    // only moves once ready is already high again.
    assign chi_shen = (state_reg == ST_NEXT) & last & shift_lat_reg;
    assign ready    = (state_reg == ST_IDLE) & ~start;
    assign result   = acc_reg;

endmodule

// File: tb/tb_verifier_chi_dot_accum.sv
// Table-driven bench for verifier_chi_dot_accum with an expected-result queue
// and hand-written sequences for reset, re-trigger and mid-chunk reset.
module tb_verifier_chi_dot_accum;

    localparam int NB = 16;
    localparam longint P = 65521;
    localparam int NVEC = 12;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 en;
    logic                 clr_acc;
    logic                 shift_req;
    logic [3:0][NB-1:0]   chi_in;
    logic [3:0][NB-1:0]   vals_in;
    logic                 chi_shen;
    logic                 ready;
    logic [NB-1:0]        result;

    always #5 clk = ~clk;

    verifier_chi_dot_accum #(.nValBits(2)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .clr_acc   (clr_acc),
        .shift_req (shift_req),
        .chi_in    (chi_in),
        .vals_in   (vals_in),
        .chi_shen  (chi_shen),
        .ready     (ready),
        .result    (result)
    );

    typedef struct {
        logic               clr;
        logic               shift;
        logic [3:0][NB-1:0] chi;
        logic [3:0][NB-1:0] vals;
        logic [NB-1:0]      expv;
    } vec_t;

    vec_t          vecs[NVEC];
    logic [NB-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            last_busy;

    function automatic logic [3:0][NB-1:0] pack4(input int e0, input int e1,
                                                  input int e2, input int e3);
        logic [3:0][NB-1:0] r;
        r[0] = NB'(e0);
        r[1] = NB'(e1);
        r[2] = NB'(e2);
        r[3] = NB'(e3);
        return r;
    endfunction

    // Reference dot product using native wide arithmetic.
    function automatic logic [NB-1:0] model(input logic [3:0][NB-1:0] c,
                                            input logic [3:0][NB-1:0] v,
                                            input longint acc_in);
        longint acc;
        acc = acc_in;
        for (int i = 0; i < 4; i++) begin
            acc = (acc + (longint'(c[i]) * longint'(v[i])) % P) % P;
        end
        return NB'(acc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic run_chunk(input vec_t v, input bit repulse, input string name);
        int  busy;
        int  shen_cnt;
        bit  shen_last;
        bit  done;
        int  stray;
        logic [NB-1:0] expv;
        @(negedge clk);
        chi_in    = v.chi;
        vals_in   = v.vals;
        clr_acc   = v.clr;
        shift_req = v.shift;
        en        = 1'b1;
        exp_q.push_back(v.expv);
        @(posedge clk);
        #1 en = 1'b0;
        busy      = 1;
        shen_cnt  = 0;
        shen_last = 1'b0;
        done      = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            shen_cnt += int'(chi_shen);
            if (ready) begin
                done = 1'b1;
            end else begin
                busy++;
                shen_last = chi_shen;
            end
            if (repulse && busy == 6) en = 1'b1;
            if (repulse && busy == 7) en = 1'b0;
        end
        last_busy = busy;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ready still 0, required 1", name);
            void'(exp_q.pop_front());
        end else begin
            expv = exp_q.pop_front();
            $display("txn %s: result=%0d expected=%0d busy=%0d shen=%0d", name, result, expv, busy, shen_cnt);
            check({name, " result"}, 32'(result), 32'(expv));
            check({name, " reduced"}, 32'(longint'(result) < P), 32'd1);
            check({name, " shen count"}, 32'(shen_cnt), 32'(v.shift));
            if (v.shift) check({name, " shen before ready"}, 32'(shen_last), 32'd1);
        end
        if (repulse) begin
            en    = 1'b0;
            stray = 0;
            repeat (8) begin
                @(negedge clk);
                if (!ready) stray++;
            end
            check({name, " no second run"}, 32'(stray), 32'd0);
        end
    endtask

    initial begin
        int     b_one;
        int     shen_seen;
        int     not_ready;
        vec_t   v;

        vecs[0] = '{clr:1'b1, shift:1'b0, chi:pack4(1,0,0,0), vals:pack4(5,6,7,8), expv:16'd5};
        vecs[1] = '{clr:1'b1, shift:1'b0, chi:pack4(1,1,1,1), vals:pack4(1,2,3,4), expv:16'd10};
        vecs[2] = '{clr:1'b0, shift:1'b0, chi:pack4(1,1,1,1), vals:pack4(1,2,3,4), expv:16'd20};
        vecs[3] = '{clr:1'b1, shift:1'b0, chi:pack4(65520,65520,0,0), vals:pack4(65520,2,9,9), expv:16'd65520};
        vecs[4] = '{clr:1'b0, shift:1'b0, chi:pack4(2,0,0,0), vals:pack4(1,0,0,0), expv:16'd1};
        vecs[5] = '{clr:1'b1, shift:1'b1, chi:pack4(1000,2000,3,0), vals:pack4(3000,4000,5,7), expv:16'd58008};
        vecs[6] = '{clr:1'b1, shift:1'b0, chi:pack4(0,0,0,0), vals:pack4(9,9,9,9), expv:16'd0};
        vecs[7] = '{clr:1'b1, shift:1'b1, chi:pack4(7,0,0,0), vals:pack4(9,0,0,0), expv:16'd63};
        for (int i = 8; i < NVEC; i++) begin
            for (int k = 0; k < 4; k++) begin
                vecs[i].chi[k]  = ($urandom_range(0, 3) == 0) ? 16'd0 : NB'($urandom_range(1, 65520));
                vecs[i].vals[k] = NB'($urandom_range(0, 65520));
            end
            vecs[i].clr   = 1'b1;
            vecs[i].shift = 1'(i % 2);
            vecs[i].expv  = model(vecs[i].chi, vecs[i].vals, 0);
        end

        // Reset with en held high: leaving reset must not look like a rising edge.
        rstb      = 1'b0;
        en        = 1'b1;
        clr_acc   = 1'b0;
        shift_req = 1'b0;
        chi_in    = '0;
        vals_in   = '0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        shen_seen = 0;
        not_ready = 0;
        repeat (6) begin
            @(negedge clk);
            if (!ready) not_ready++;
            shen_seen += int'(chi_shen);
        end
        check("reset ready", 32'(not_ready), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset chi_shen", 32'(shen_seen), 32'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_chunk(vecs[i], 1'b0, $sformatf("vec%0d", i));
            if (i == 0) b_one = last_busy;
            if (i == 1) check("latency skip consistency", 32'(last_busy), 32'(1 + 4 * (b_one - 7)));
            if (i == 6) check("latency all skipped", 32'(last_busy), 32'd9);
        end

        // Rising edge on en while busy must be dropped.
        v = '{clr:1'b1, shift:1'b0, chi:pack4(3,4,0,0), vals:pack4(5,6,0,0), expv:16'd39};
        run_chunk(v, 1'b1, "repulse");

        // Asynchronous reset in the middle of a chunk.
        @(negedge clk);
        chi_in    = pack4(1, 1, 1, 1);
        vals_in   = pack4(1, 2, 3, 4);
        clr_acc   = 1'b0;
        shift_req = 1'b1;
        en        = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun busy", 32'(ready), 32'd0);
        #1 rstb = 1'b0;
        #1;
        check("midrun reset ready", 32'(ready), 32'd1);
        check("midrun reset result", 32'(result), 32'd0);
        check("midrun reset chi_shen", 32'(chi_shen), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        v = '{clr:1'b0, shift:1'b0, chi:pack4(1,1,1,1), vals:pack4(1,2,3,4), expv:16'd10};
        run_chunk(v, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
